// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO between EXE/MEM and data memory with store-to-load forwarding
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mr,
    input  logic [31:0] mqb,
    input  logic        mwmem,
    input  logic        mm2reg,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mdo,
    output logic        stall,
    output logic        empty
);

    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_drain;
    logic             w_push;
    logic             w_fwd_hit;
    logic [31:0]      w_fwd_data;
    logic [PTR_W-1:0] w_idx;
    logic             w_unused;

    assign w_unused = ^mr[1:0];
    assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
    // A load owns the memory port, so draining only happens on non-load cycles.
    assign w_drain  = !mm2reg && (r_count != '0);
    assign w_push   = mwmem && !w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_drain) begin
                r_valid[r_rp] <= 1'b0;
                r_rp          <= r_rp + 1'b1;
            end
            if (w_push) begin
                r_addr[r_wp]  <= mr[31:2];
                r_data[r_wp]  <= mqb;
                r_valid[r_wp] <= 1'b1;
                r_wp          <= r_wp + 1'b1;
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rp + PTR_W'(k);
            if (r_valid[w_idx] && (r_addr[w_idx] == mr[31:2])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    always_comb begin
        mem_we    = !rst && w_drain;
        mem_wdata = (!rst && w_drain) ? r_data[r_rp] : 32'h0;
        if (rst)
            mem_addr = 32'h0;
        else if (w_drain)
            mem_addr = {r_addr[r_rp], 2'b00};
        else
            mem_addr = {mr[31:2], 2'b00};
        mdo   = (!rst && w_fwd_hit) ? w_fwd_data : mem_rdata;
        stall = !rst && mwmem && w_full;
        empty = rst || (r_count == '0);
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed scoreboard bench for store_buffer
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mr, mqb;
    logic        mwmem, mm2reg;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, mdo;
    logic        mem_we, stall, empty;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;
    ent_t pend[$];

    int total = 0;
    int bad = 0;
    int n_writes = 0;
    int n_exp_writes = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .mr(mr), .mqb(mqb), .mwmem(mwmem), .mm2reg(mm2reg),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mdo(mdo), .stall(stall), .empty(empty)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr[7:2]] = mem_wdata;
            n_writes++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic we, input logic ld, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp_mdo;
        bit          exp_stall;
        bit          drn;
        @(posedge clk);
        #1;
        mwmem = we; mm2reg = ld; mr = a; mqb = d;
        #2;
        exp_stall = we && (pend.size() == DEPTH);
        drn       = !ld && (pend.size() != 0);
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        chk("empty", {31'b0, empty}, {31'b0, pend.size() == 0});
        chk("mem_we", {31'b0, mem_we}, {31'b0, drn});
        if (ld) begin
            exp_mdo = ref_mem[a[7:2]];
            foreach (pend[i])
                if (pend[i].a[31:2] == a[31:2]) exp_mdo = pend[i].d;
            chk("mdo", mdo, exp_mdo);
            chk("ld_addr", mem_addr, {a[31:2], 2'b00});
        end
        if (drn) begin
            chk("drain_addr", mem_addr, {pend[0].a[31:2], 2'b00});
            chk("drain_data", mem_wdata, pend[0].d);
            ref_mem[pend[0].a[7:2]] = pend[0].d;
            void'(pend.pop_front());
            n_exp_writes++;
        end
        if (we && !exp_stall) pend.push_back('{a, d});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; mwmem = 1'b0; mm2reg = 1'b0; mr = '0; mqb = '0;
        pend.delete();
        #2;
        chk("rst_we", {31'b0, mem_we}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_empty", {31'b0, empty}, 32'h1);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_mdo", mdo, mem[0]);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_mem(input string tag);
        int diffs = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        chk(tag, diffs, 0);
    endtask

    initial begin
        rst = 1'b1; mwmem = 1'b0; mm2reg = 1'b0; mr = '0; mqb = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = (32'(i) << 28) | (32'(i) * 32'h11);
            ref_mem[i] = mem[i];
        end
        do_reset();

        step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h08, 32'h0);
        chk("lw8_init", mdo, 32'h20000022);

        // Fill with loads held so nothing drains, then reset discards them.
        step(1'b1, 1'b1, 32'h0C, 32'h11110000);
        step(1'b1, 1'b1, 32'h10, 32'h22220000);
        step(1'b1, 1'b1, 32'h14, 32'h33330000);
        do_reset();
        step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h0C, 32'h0);
        chk("lw0c_after_rst", mdo, 32'h30000033);
        chk("no_writes_rst", n_writes, 0);

        step(1'b1, 1'b0, 32'h08, 32'h12345678);
        step(1'b0, 1'b1, 32'h08, 32'h0);
        chk("fwd_lw8", mdo, 32'h12345678);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h08, 32'h0);
        chk("mem_lw8", mdo, 32'h12345678);

        step(1'b1, 1'b1, 32'h0C, 32'hAAAA0001);
        step(1'b1, 1'b1, 32'h0C, 32'hBBBB0002);
        step(1'b0, 1'b1, 32'h0D, 32'h0);
        chk("youngest", mdo, 32'hBBBB0002);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 32'h0);

        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b1, 32'h20 + 32'(4 * k), 32'hF0000000 + 32'(k));
        step(1'b1, 1'b0, 32'h30, 32'h55555555);
        chk("full_stall", {31'b0, stall}, 32'h1);
        step(1'b1, 1'b0, 32'h30, 32'h55555555);
        chk("full_accept", {31'b0, stall}, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
        chk_mem("mem_after_full");

        for (int k = 0; k < 2 * DEPTH + 1; k++)
            step(1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'hC0DE0000 + 32'(k));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("empty_end", {31'b0, empty}, 32'h1);
        chk_mem("mem_after_wrap");
        chk("n_writes", n_writes, n_exp_writes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer between the EXE/MEM pipeline register and the data memory.
- Stores (sw) are queued in a small FIFO and drained to the data memory one word per cycle, whenever the memory port is not needed by a load.
- Loads (lw) read memory combinationally. They take data from the youngest matching buffered store if one exists (store-to-load forwarding).
- Asserts a stall to the pipeline when a store arrives and the buffer is full.

Parameters:
- DEPTH, 4: number of buffered stores; power of two, at least 2.
- PTR_W, 2: log2(DEPTH); width of the read and write pointers.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  synchronous active-high reset.
- mr  input  32  load/store byte address from EXE/MEM; bits [1:0] ignored (word access only).
- mqb  input  32  store data from EXE/MEM.
- mwmem  input  1  store request this cycle.
- mm2reg  input  1  load request this cycle; never asserted together with mwmem.
- mem_addr  output  32  address driven to the data memory port.
- mem_wdata  output  32  write data driven to the data memory.
- mem_we  output  1  write enable to the data memory; memory writes on negedge of the same cycle.
- mem_rdata  input  32  combinational read data from the data memory.
- mdo  output  32  load result to MEM/WB (forwarded or memory data).
- stall  output  1  pipeline hold request; upstream keeps mr/mqb/mwmem stable while high.
- empty  output  1  buffer holds no pending stores.

Behaviour:
- State:
  - DEPTH entries of {addr[31:2], data[31:0], valid}.
  - Write pointer wp and read pointer rp, each PTR_W bits, wrapping modulo DEPTH.
  - count, PTR_W+1 bits.
- Reset (posedge clk with rst=1):
  - wp=rp=0, count=0, all valid=0.
  - Pending stores are discarded and never written to memory.
  - During and immediately after reset: mem_we=0, stall=0, empty=1, mem_addr=0, mem_wdata=0, mdo=mem_rdata.
- Port arbitration (combinational):
  - Load cycle (mm2reg=1):
    - mem_addr = {mr[31:2],2'b00}, mem_we=0.
    - No drain this cycle.
  - Drain cycle (mm2reg=0 and count>0):
    - mem_addr = {head.addr,2'b00}, mem_wdata = head.data, mem_we=1.
    - At posedge: rp increments, head valid clears, count decrements.
  - Idle (mm2reg=0 and count=0):
    - mem_addr = {mr[31:2],2'b00}, mem_wdata=0, mem_we=0.
- Push:
  - Occurs when mwmem=1 and count<DEPTH.
  - At posedge: entry[wp] = {mr[31:2], mqb, 1}, wp increments, count increments.
- Simultaneous push and drain: count unchanged; rp and wp both advance.
- Full:
  - stall = mwmem & (count==DEPTH), combinational.
  - The store is not accepted that cycle.
  - Drain still proceeds because mm2reg=0, so the store is accepted the next cycle.
  - No same-cycle pop-to-push bypass when full.
- Load forwarding:
  - mdo = data of the youngest valid entry whose addr equals mr[31:2].
  - Youngest means nearest behind wp, scanning wp-1 down to rp with wrap.
  - With no match, mdo = mem_rdata.
  - Zero-latency: combinational, same cycle as mm2reg.
  - Multiple matching entries: youngest wins.
- empty = (count==0).
- count never exceeds DEPTH and never underflows; pointers wrap silently.
- Memory ordering: stores reach memory in program order.

Test Plan:
- Reset, then lw address 0x08 with buffer empty -> mdo=0x20000022 (memory word 2), mem_we=0, empty=1.
- sw 0x12345678 to 0x08, then next cycle lw 0x08 -> on the lw cycle, forwarding returns mdo=0x12345678 (no port-conflict drain), then the following idle cycle drains with mem_we=1, mem_addr=0x08; a later lw 0x08 with empty=1 -> mdo=0x12345678 from memory.
- Two sw to 0x0C (0xAAAA0001, then 0xBBBB0002) with back-to-back lw held so no drain occurs, then lw 0x0C -> mdo=0xBBBB0002 (youngest wins).
- Four sw while mm2reg held high on alternate cycles so the buffer reaches count=4, then a fifth sw -> stall=1 for exactly one cycle, head drained that cycle, store accepted next cycle; final memory contents match program order.
- Push/drain across wrap: 2*DEPTH+1 consecutive sw to distinct addresses with no loads -> stall never asserted, each word written exactly once in order, empty=1 one cycle after the last sw.
- Fill buffer with 3 stores, assert rst for one cycle -> empty=1, mem_we=0 thereafter, and lw of those addresses returns the original memory values (e.g. 0x30000033 at 0x0C).
